// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the serial-in / parallel-out frame receiver.
package sipo_rx_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 2;

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} rx_state_e;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;
endpackage

// File: rtl/sipo_frame_rx_if.sv
// Bundle of serial input, word output and status signals of sipo_frame_rx.
interface sipo_frame_rx_if #(parameter int WIDTH = sipo_rx_pkg::DEF_WIDTH);
   import sipo_rx_pkg::*;

   // Output handshake: a word transfers on every rising edge where rx_valid and
   // rx_ready are both 1; rx_data/rx_valid stay stable while rx_ready is 0.
   logic             si;
   logic             si_valid;
   logic             sof;
   logic             rx_ready;
   logic             ovf_clr;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;
   logic             frame_err;
   logic             overflow;
   rx_state_e        state_dbg;

   modport master (
      output si, si_valid, sof, rx_ready, ovf_clr,
      input  rx_data, rx_valid, busy, frame_err, overflow, state_dbg
   );

   modport slave (
      input  si, si_valid, sof, rx_ready, ovf_clr,
      output rx_data, rx_valid, busy, frame_err, overflow, state_dbg
   );
endinterface

// File: rtl/rx_fifo.sv
// Small synchronous FIFO holding completed words; head word is shown combinationally.
module rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] data
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is still taken when the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign data  = mem[rd_ptr];
endmodule

// File: rtl/sipo_frame_rx.sv
// Assembles MSB-first serial frames delimited by sof into WIDTH-bit words and
// queues them for a valid/ready consumer.
module sipo_frame_rx
   import sipo_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic            clk,
   input logic            rst,
   sipo_frame_rx_if.slave bus
);
   localparam int CNTW = $clog2(WIDTH + 1);

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CNTW-1:0]  bit_cnt;
   logic             frame_err_q;
   logic             overflow_q;
   logic [WIDTH-1:0] shifted;
   logic             abort;
   logic             done;
   logic             pop;
   logic             drop;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] head;

   assign shifted = {shreg[WIDTH-2:0], bus.si};
   // sof always wins over completion, so a sof on the last bit is an abort.
   assign abort   = bus.si_valid && bus.sof && (state == ST_SHIFT);
   assign done    = bus.si_valid && !bus.sof && (state == ST_SHIFT) &&
                    (bit_cnt == CNTW'(WIDTH - 1));
   assign pop     = bus.rx_ready && !empty;
   assign drop    = done && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= abort;
         if (drop)             overflow_q <= 1'b1;
         else if (bus.ovf_clr) overflow_q <= 1'b0;

         if (bus.si_valid) begin
            if (bus.sof) begin
               shreg   <= {{(WIDTH-1){1'b0}}, bus.si};
               bit_cnt <= CNTW'(1);
               state   <= ST_SHIFT;
            end else if (state == ST_SHIFT) begin
               shreg <= shifted;
               if (done) begin
                  bit_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + CNTW'(1);
               end
            end
         end
      end
   end

   rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (done),
      .push_data (shifted),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .data      (head)
   );

   assign bus.rx_data   = head;
   assign bus.rx_valid  = !empty;
   assign bus.busy      = (state == ST_SHIFT);
   assign bus.frame_err = frame_err_q;
   assign bus.overflow  = overflow_q;
   assign bus.state_dbg = rx_state_e'(state);
endmodule
